// File: rtl/fetch_bpred_unit_if.sv
// Fetch/branch-resolution bundle between the hazard unit, ID stage and the fetch predictor.
// slave is the fetch unit's view; master is the surrounding pipeline's view.
interface fetch_bpred_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall_if;
    logic            res_valid;
    logic [XLEN-1:0] res_pc;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic            res_pred_taken;
    logic [XLEN-1:0] res_pred_target;
    logic [XLEN-1:0] pc_if;
    logic [XLEN-1:0] pcplus4_if;
    logic            pred_taken_if;
    logic [XLEN-1:0] pred_target_if;
    logic            flush_if;

    modport master (
        output stall_if, res_valid, res_pc, res_taken, res_target, res_pred_taken,
               res_pred_target,
        input  pc_if, pcplus4_if, pred_taken_if, pred_target_if, flush_if
    );

    modport slave (
        input  stall_if, res_valid, res_pc, res_taken, res_target, res_pred_taken,
               res_pred_target,
        output pc_if, pcplus4_if, pred_taken_if, pred_target_if, flush_if
    );
endinterface

// File: rtl/fetch_bpred_unit.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating counters.
// Define BPRED_STATS_EN to add saturating branch/mispredict counters as extra outputs.
module fetch_bpred_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    fetch_bpred_unit_if.slave  bus
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);
    localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDXW - 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pcplus4;

    logic            valid_q  [BTB_ENTRIES];
    logic [1:0]      ctr_q    [BTB_ENTRIES];
    logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0] target_q [BTB_ENTRIES];

    logic [IDXW-1:0] look_idx, res_idx;
    logic [TAGW-1:0] look_tag, res_tag;
    logic            look_hit, res_hit;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            mispredict;

    logic            upd_en;
    logic [1:0]      upd_ctr;
    logic [XLEN-1:0] upd_target;

    assign pcplus4  = pc_q + XLEN'(4);
    assign look_idx = pc_q[IDXW+1:2];
    assign look_tag = pc_q[XLEN-1:IDXW+2];
    assign res_idx  = bus.res_pc[IDXW+1:2];
    assign res_tag  = bus.res_pc[XLEN-1:IDXW+2];

    // Lookup reads pre-update contents; no bypass from a same-cycle resolution.
    assign look_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    assign pred_taken  = look_hit && ctr_q[look_idx][1];
    assign pred_target = look_hit ? target_q[look_idx] : pcplus4;

    assign mispredict = bus.res_valid &&
                        ((bus.res_taken != bus.res_pred_taken) ||
                         (bus.res_taken && bus.res_pred_taken &&
                          (bus.res_target != bus.res_pred_target)));

    assign bus.pc_if          = pc_q;
    assign bus.pcplus4_if     = pcplus4;
    assign bus.pred_taken_if  = pred_taken;
    assign bus.pred_target_if = pred_target;
    assign bus.flush_if       = mispredict;

    always_comb begin
        pc_d = pcplus4;
        if (mispredict) begin
            pc_d = bus.res_taken ? bus.res_target : bus.res_pc + XLEN'(4);
        end else if (bus.stall_if) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);

    always_comb begin
        upd_en     = bus.res_valid && (res_hit || bus.res_taken);
        upd_ctr    = 2'b10;
        upd_target = bus.res_taken ? bus.res_target : target_q[res_idx];
        if (res_hit) begin
            upd_ctr = ctr_q[res_idx];
            if (bus.res_taken && ctr_q[res_idx] != 2'b11) begin
                upd_ctr = ctr_q[res_idx] + 2'd1;
            end else if (!bus.res_taken && ctr_q[res_idx] != 2'b00) begin
                upd_ctr = ctr_q[res_idx] - 2'd1;
            end
        end
    end

    // A miss always allocates here, so writing the tag is harmless on a hit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                ctr_q[i]    <= 2'b01;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (upd_en) begin
            valid_q[res_idx]  <= 1'b1;
            ctr_q[res_idx]    <= upd_ctr;
            tag_q[res_idx]    <= res_tag;
            target_q[res_idx] <= upd_target;
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] branches_q, mispredicts_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (bus.res_valid && branches_q != 32'hFFFF_FFFF) begin
                branches_q <= branches_q + 32'd1;
            end
            if (mispredict && mispredicts_q != 32'hFFFF_FFFF) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`endif
endmodule

// File: tb/tb_fetch_bpred_unit.sv
// Directed bench for fetch_bpred_unit: sequential fetch, BTB allocate/train/alias,
// stall vs redirect, target change, PC wrap and asynchronous reset.
module tb_fetch_bpred_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fetch_bpred_unit_if #(.XLEN(32)) bus ();

    fetch_bpred_unit #(
        .XLEN        (32),
        .BTB_ENTRIES (16),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef BPRED_STATS_EN
        ,
        .stat_branches    (),
        .stat_mispredicts ()
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_res(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic ptaken, input logic [31:0] ptgt);
        bus.res_valid       = 1'b1;
        bus.res_pc          = pc;
        bus.res_taken       = taken;
        bus.res_target      = tgt;
        bus.res_pred_taken  = ptaken;
        bus.res_pred_target = ptgt;
        #1;
    endtask

    task automatic clear_res();
        bus.res_valid = 1'b0;
        #1;
    endtask

    // Redirect by a not-taken mispredict at addr-4; every addr-4 used maps to a cold entry.
    task automatic goto_pc(input logic [31:0] addr);
        drive_res(addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        clear_res();
    endtask

    initial begin
        n_checks            = 0;
        n_errors            = 0;
        reset               = 1'b0;
        bus.stall_if        = 1'b0;
        bus.res_valid       = 1'b0;
        bus.res_pc          = '0;
        bus.res_taken       = 1'b0;
        bus.res_target      = '0;
        bus.res_pred_taken  = 1'b0;
        bus.res_pred_target = '0;
        #2;
        check("reset_pc", bus.pc_if, 32'h0);
        check("reset_pred", 32'(bus.pred_taken_if), 32'h0);
        check("reset_flush", 32'(bus.flush_if), 32'h0);

        // Sequential fetch after reset release
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("seq_pc0", bus.pc_if, 32'h0);
        tick();
        check("seq_pc4", bus.pc_if, 32'h4);
        tick();
        check("seq_pc8", bus.pc_if, 32'h8);
        tick();
        check("seq_pcC", bus.pc_if, 32'hC);
        check("seq_pred", 32'(bus.pred_taken_if), 32'h0);
        check("seq_flush", 32'(bus.flush_if), 32'h0);
        tick();
        check("seq_pc10", bus.pc_if, 32'h10);
        check("cold_pred_target", bus.pred_target_if, 32'h14);

        // Cold taken branch allocates entry 4 with ctr=10
        drive_res(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
        check("cold_flush", 32'(bus.flush_if), 32'h1);
        tick();
        clear_res();
        check("cold_redirect_pc", bus.pc_if, 32'h40);
        goto_pc(32'h10);
        check("alloc_pred", 32'(bus.pred_taken_if), 32'h1);
        check("alloc_target", bus.pred_target_if, 32'h40);
        tick();
        check("alloc_follow_pc", bus.pc_if, 32'h40);

        // Hysteresis: 10 -> 01 (not taken), then up to 11 and saturate
        drive_res(32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
        check("nt_flush", 32'(bus.flush_if), 32'h1);
        tick();
        clear_res();
        check("nt_pc", bus.pc_if, 32'h14);
        goto_pc(32'h10);
        check("ctr01_pred", 32'(bus.pred_taken_if), 32'h0);
        check("ctr01_target", bus.pred_target_if, 32'h40);
        for (int i = 0; i < 3; i++) begin
            drive_res(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
            check("correct_pred_flush", 32'(bus.flush_if), 32'h0);
            tick();
        end
        clear_res();
        goto_pc(32'h10);
        check("ctr11_pred", 32'(bus.pred_taken_if), 32'h1);
        drive_res(32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
        tick();
        clear_res();
        goto_pc(32'h10);
        check("ctr_sat_pred", 32'(bus.pred_taken_if), 32'h1);

        // Aliasing: 0x50 evicts 0x10 from entry 4
        drive_res(32'h50, 1'b1, 32'h90, 1'b0, 32'h0);
        check("alias_flush", 32'(bus.flush_if), 32'h1);
        tick();
        clear_res();
        check("alias_pc", bus.pc_if, 32'h90);
        goto_pc(32'h10);
        check("alias_old_miss", 32'(bus.pred_taken_if), 32'h0);
        goto_pc(32'h50);
        check("alias_new_hit", 32'(bus.pred_taken_if), 32'h1);
        check("alias_new_target", bus.pred_target_if, 32'h90);
        tick();
        check("alias_follow_pc", bus.pc_if, 32'h90);

        // Redirect overrides stall; then stall holds
        bus.stall_if = 1'b1;
        drive_res(32'h20, 1'b1, 32'h80, 1'b0, 32'h0);
        check("stall_redirect_flush", 32'(bus.flush_if), 32'h1);
        tick();
        clear_res();
        check("stall_redirect_pc", bus.pc_if, 32'h80);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_pc", bus.pc_if, 32'h80);
        end
        bus.stall_if = 1'b0;

        // Address wrap
        goto_pc(32'hFFFF_FFFC);
        check("wrap_pcplus4", bus.pcplus4_if, 32'h0);
        tick();
        check("wrap_pc", bus.pc_if, 32'h0);
        drive_res(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        clear_res();
        check("wrap_res_pc4", bus.pc_if, 32'h0);

        // Target change, then mid-cycle reset
        drive_res(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
        tick();
        clear_res();
        goto_pc(32'h10);
        check("retrain_target", bus.pred_target_if, 32'h40);
        drive_res(32'h10, 1'b1, 32'h60, 1'b1, 32'h40);
        check("tgt_change_flush", 32'(bus.flush_if), 32'h1);
        tick();
        clear_res();
        check("tgt_change_pc", bus.pc_if, 32'h60);
        goto_pc(32'h10);
        check("tgt_change_stored", bus.pred_target_if, 32'h60);
        check("tgt_change_pred", 32'(bus.pred_taken_if), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_pc", bus.pc_if, 32'h0);
        check("async_reset_pred", 32'(bus.pred_taken_if), 32'h0);
        tick();
        reset = 1'b1;
        #1;
        goto_pc(32'h10);
        check("post_reset_miss", 32'(bus.pred_taken_if), 32'h0);
        check("post_reset_target", bus.pred_target_if, 32'h14);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_bpred_unit.md
Name: fetch_bpred_unit

Overview:
Parametrised fetch stage for the pipelined MIPS core: the next generation of the fetch logic in the pipelined datapath. It adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches and jumps redirect in IF instead of waiting for ID resolution. It sits between the instruction memory address port and the IF/ID buffer, takes branch resolution from ID, and raises a one-cycle IF flush on misprediction.

Parameters:
XLEN, 32, width of PC and targets
BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
stall_if  input  1  hold PC (from hazard unit); ignored while a redirect is active
res_valid  input  1  a branch or jump in ID resolves this cycle
res_pc  input  XLEN  PC of the resolving instruction
res_taken  input  1  actual direction (jumps: 1)
res_target  input  XLEN  actual target when taken
res_pred_taken  input  1  prediction carried down the pipe for this instruction
res_pred_target  input  XLEN  predicted target carried down the pipe
pc_if  output  XLEN  current fetch PC, to instruction memory
pcplus4_if  output  XLEN  pc_if + 4
pred_taken_if  output  1  BTB prediction for pc_if
pred_target_if  output  XLEN  predicted target (valid when pred_taken_if = 1)
flush_if  output  1  redirect this cycle; squash the IF/ID buffer contents

Behaviour:
- Reset (async, reset=0): pc_if=RESET_PC; all BTB valid bits=0; counters=2'b01; targets and tags=0. Outputs then: pred_taken_if=0, flush_if=0.
- Index = pc[IDXW+1:2], where IDXW=log2(BTB_ENTRIES). Tag = pc[XLEN-1:IDXW+2]. Bits [1:0] ignored.
- Lookup is combinational on pc_if. hit = valid & tag match. pred_taken_if = hit & ctr[1]. pred_target_if = stored target when hit, else pcplus4_if.
- mispredict = res_valid & ((res_taken != res_pred_taken) | (res_taken & res_pred_taken & res_target != res_pred_target)). flush_if = mispredict; the output is combinational.
- Next-PC priority, evaluated each cycle:
  1. mispredict: res_taken ? res_target : res_pc+4
  2. stall_if: hold
  3. pred_taken_if: pred_target_if
  4. else pcplus4_if
- BTB update on a rising edge when res_valid=1, indexed by res_pc:
  - On tag match: counter saturates up if taken, down if not taken (no wrap past 2'b11 or 2'b00). Target is rewritten with res_target if taken.
  - On miss and taken: allocate the entry, overwriting any occupant. Set valid=1, tag, target=res_target, ctr=2'b10.
  - On miss and not taken: no change.
  - The update happens regardless of stall_if.
- Same-cycle lookup and update of one index: the lookup sees the pre-update contents. There is no bypass.
- All arithmetic is modulo 2^XLEN. pc+4 wraps from the top of the address space to 0.
- Reset asserted mid-operation clears the BTB and PC immediately. Any in-flight res_* is dropped.

Optional Feature:
BPRED_STATS_EN: adds outputs stat_branches and stat_mispredicts (each 32 bits).
- stat_branches increments on each res_valid; stat_mispredicts increments on each mispredict.
- Both saturate at 32'hFFFF_FFFF and clear on reset.
- Without the macro, these ports and counters do not exist. Prediction behaviour is identical either way.

Test Plan:
- Reset then release, stall_if=0, no res_valid: pc_if goes 0,4,8,C on successive cycles; pred_taken_if=0 and flush_if=0 throughout.
- Cold taken branch: res_valid, res_pc=0x10, res_taken=1, res_target=0x40, res_pred_taken=0. Required: flush_if=1 that cycle and next pc_if=0x40. Entry 4 is allocated with ctr=10. The next fetch of 0x10 gives pred_taken_if=1, pred_target_if=0x40, and the following pc_if=0x40.
- Counter hysteresis: starting from ctr=10 at 0x10, resolve not-taken once. Required: ctr=01, flush_if=1, next pc_if=0x14. The next fetch of 0x10 predicts not-taken. Two taken resolutions restore ctr to 11; a third taken resolution keeps it at 11.
- Aliasing (BTB_ENTRIES=16): entry holds 0x10. Resolve taken at 0x50 (same index, different tag). Required: the entry is replaced. A fetch at 0x10 then misses (pred_taken_if=0); a fetch at 0x50 hits.
- Redirect during stall: stall_if=1 with a mispredict resolving (taken, target 0x80). Required: pc_if=0x80 on the next edge and flush_if=1. With stall_if=1 and no mispredict, pc_if holds for 3 cycles.
- Target change plus reset: entry at 0x10 predicts 0x40; resolve taken to 0x60 with res_pred_target=0x40. Required: mispredict, next pc=0x60, stored target becomes 0x60. Then assert reset mid-cycle: pc_if=0 immediately, and a later fetch of 0x10 misses.
